// File: rtl/cpu_program_loader_if.sv
// -----------------------------------------------------------------------------
// cpu_program_loader_if
//
// Purpose:
//   Bundles the byte-stream handshake and the instruction-memory load port
//   used by cpu_program_loader.
//
// Signals:
//   start_i          session start pulse (host -> loader)
//   byte_i           stream data byte (host -> loader)
//   byte_valid_i     byte_i holds a valid byte (host -> loader)
//   byte_ready_o     loader can accept a byte (loader -> host)
//   we_im_o          instruction-memory write strobe (loader -> CPU we_im_i)
//   code_o           instruction word (loader -> CPU code_i)
//   immed_address_o  write address (loader -> CPU immed_address_i)
//   en_o             CPU enable (loader -> CPU EN_i)
//   busy_o           session in progress
//   done_o           image loaded successfully
//   err_o            header word count out of range
//
// Modports:
//   master  the loader side
//   slave   the host / CPU side
// -----------------------------------------------------------------------------
interface cpu_program_loader_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
);
    logic              start_i;
    logic [7:0]        byte_i;
    logic              byte_valid_i;
    logic              byte_ready_o;
    logic              we_im_o;
    logic [DATA_W-1:0] code_o;
    logic [ADDR_W-1:0] immed_address_o;
    logic              en_o;
    logic              busy_o;
    logic              done_o;
    logic              err_o;

    modport master (
        input  start_i,
        input  byte_i,
        input  byte_valid_i,
        output byte_ready_o,
        output we_im_o,
        output code_o,
        output immed_address_o,
        output en_o,
        output busy_o,
        output done_o,
        output err_o
    );

    modport slave (
        output start_i,
        output byte_i,
        output byte_valid_i,
        input  byte_ready_o,
        input  we_im_o,
        input  code_o,
        input  immed_address_o,
        input  en_o,
        input  busy_o,
        input  done_o,
        input  err_o
    );
endinterface

// File: rtl/cpu_program_loader.sv
// -----------------------------------------------------------------------------
// cpu_program_loader
//
// Purpose:
//   Loads a program image into the CPU_16_bits instruction memory from a byte
//   stream. The stream is a 2-byte word count N (high byte first) followed by
//   N 16-bit instruction words (high byte first). Words are written to
//   consecutive addresses starting at 0, one single-cycle write strobe per
//   word. The CPU is held disabled while loading and enabled once the whole
//   image has been written.
//
// Parameters:
//   DATA_W  instruction word width; must be 16 (two bytes per word)
//   ADDR_W  instruction address width
//   DEPTH   maximum accepted word count; must be <= 2**ADDR_W
//
// Ports:
//   clk_i   clock, all state changes on the rising edge
//   rst_i   synchronous active-high reset
//   bus     cpu_program_loader_if.master: byte stream handshake, start pulse,
//           instruction-memory load port, CPU enable and status flags
// -----------------------------------------------------------------------------
module cpu_program_loader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4096
) (
    input logic                  clk_i,
    input logic                  rst_i,
    cpu_program_loader_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_HI,
        S_CNT_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state;
    state_t            state_nxt;

    // Shared high-byte holding register: count high byte during the header,
    // instruction high byte during each data word.
    logic [7:0]        hi_byte;
    logic [15:0]       word_count;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] code;

    logic              ready;
    logic              xfer;
    logic              start_ok;
    logic [15:0]       n_rx;
    logic              last_word;

    assign ready    = (state == S_CNT_HI)  || (state == S_CNT_LO) ||
                      (state == S_DATA_HI) || (state == S_DATA_LO);
    assign xfer     = ready && bus.byte_valid_i;
    assign start_ok = bus.start_i &&
                      ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));

    // Word count as it appears on the CNT_LO transfer.
    assign n_rx = {hi_byte, bus.byte_i};

    // Compared in 32 bits so that N == 2**ADDR_W does not alias to 0.
    assign last_word = ((32'(addr) + 32'd1) == 32'(word_count));

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (bus.start_i) state_nxt = S_CNT_HI;
            end
            S_CNT_HI: begin
                if (xfer) state_nxt = S_CNT_LO;
            end
            S_CNT_LO: begin
                if (xfer) begin
                    if (n_rx == 16'd0) begin
                        state_nxt = S_DONE;
                    end else if (32'(n_rx) > 32'(DEPTH)) begin
                        state_nxt = S_ERR;
                    end else begin
                        state_nxt = S_DATA_HI;
                    end
                end
            end
            S_DATA_HI: begin
                if (xfer) state_nxt = S_DATA_LO;
            end
            S_DATA_LO: begin
                if (xfer) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                state_nxt = last_word ? S_DONE : S_DATA_HI;
            end
            S_DONE, S_ERR: begin
                if (bus.start_i) state_nxt = S_CNT_HI;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath registers: byte capture, word count, write address and word.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hi_byte    <= 8'd0;
            word_count <= 16'd0;
            addr       <= '0;
            code       <= '0;
        end else begin
            if (start_ok) begin
                addr <= '0;
            end
            unique case (state)
                S_CNT_HI: begin
                    if (xfer) hi_byte <= bus.byte_i;
                end
                S_CNT_LO: begin
                    if (xfer) word_count <= n_rx;
                end
                S_DATA_HI: begin
                    if (xfer) hi_byte <= bus.byte_i;
                end
                S_DATA_LO: begin
                    if (xfer) code <= DATA_W'({hi_byte, bus.byte_i});
                end
                S_WRITE: begin
                    // Wraps only after the final word of an N == 2**ADDR_W image.
                    addr <= addr + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs are decoded from state so the write strobe lasts exactly the
    // one WRITE cycle and reset clears every flag on the following edge.
    assign bus.byte_ready_o    = ready;
    assign bus.we_im_o         = (state == S_WRITE);
    assign bus.code_o          = code;
    assign bus.immed_address_o = addr;
    assign bus.en_o            = (state == S_DONE);
    assign bus.busy_o          = (state == S_CNT_HI)  || (state == S_CNT_LO)  ||
                                 (state == S_DATA_HI) || (state == S_DATA_LO) ||
                                 (state == S_WRITE);
    assign bus.done_o          = (state == S_DONE);
    assign bus.err_o           = (state == S_ERR);

endmodule
